// File: rtl/seq_comparator_if.sv
// seq_comparator_if: operand/result handshake bundle for seq_comparator.
//   master : upstream/consumer side (drives operands, clear, out_ready)
//   slave  : comparator side (drives in_ready, out_valid, flags, result)
// Signals:
//   clear        synchronous abort
//   in_valid/in_ready, a, b, signed_mode   operand handshake
//   out_valid/out_ready, lt, eq, gt, result result handshake
interface seq_comparator_if #(
    parameter int WIDTH = 8,
    parameter int RES_W = 8
);
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [RES_W-1:0] result;

    modport master (
        output clear, in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, lt, eq, gt, result
    );

    modport slave (
        input  clear, in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, lt, eq, gt, result
    );
endinterface

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle magnitude comparator, CHUNK bits per cycle,
// MSB chunk first, terminating at the first differing chunk.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - seq_comparator_if.slave (operand and result handshakes, clear)
// Latency from accept edge to out_valid is the 1-based index of the first
// differing chunk (NCHUNK for equal operands).
module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    parameter int RES_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_comparator_if.slave    bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             lt_q, eq_q, gt_q;
    logic             in_ready_q, out_valid_q;

    logic [CHUNK-1:0] ca, cb;
    assign ca = sa[WIDTH-1 -: CHUNK];
    assign cb = sb[WIDTH-1 -: CHUNK];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sa          <= '0;
            sb          <= '0;
            cnt         <= '0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (bus.clear) begin
            // Abort wins over any handshake this cycle.
            state       <= IDLE;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Flipping the sign bit maps two's complement onto
                        // offset binary, so one unsigned compare serves both.
                        sa         <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                        sb         <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CMP;
                    end
                end
                CMP: begin
                    if (ca != cb) begin
                        lt_q        <= (ca < cb);
                        gt_q        <= (ca > cb);
                        eq_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (cnt == LAST) begin
                        eq_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        sa    <= sa << CHUNK;
                        sb    <= sb << CHUNK;
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        lt_q        <= 1'b0;
                        eq_q        <= 1'b0;
                        gt_q        <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;

    always_comb begin
        bus.result      = '0;
        bus.result[2:0] = {gt_q, eq_q, lt_q};
    end
endmodule

// File: tb/tb_seq_comparator.sv
module tb_seq_comparator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   lat;

    always #5 clk = ~clk;

    seq_comparator_if #(.WIDTH(8), .RES_W(8)) bus ();

    seq_comparator #(.WIDTH(8), .CHUNK(2), .RES_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge; returns just after the accept edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic sm);
        @(negedge clk);
        bus.a = ta; bus.b = tb; bus.signed_mode = sm; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid (bounded).
    task automatic wait_out(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] exp_res, input int exp_lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_result"}, {24'b0, bus.result}, {24'b0, exp_res});
        chk({tag, "_flags"}, {29'b0, bus.gt, bus.eq, bus.lt}, {29'b0, exp_res[2:0]});
        chk({tag, "_inrdy_busy"}, {31'b0, bus.in_ready}, 32'd0);
    endtask

    // Full op with out_ready high: result then handoff on the next edge.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic sm, input logic [7:0] exp_res, input int exp_lat);
        start_op(ta, tb, sm);
        wait_out(lat);
        check_res(tag, exp_res, exp_lat);
        @(posedge clk); #1;
        chk({tag, "_drop"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'b0, bus.in_ready}, 32'd1);
        chk({tag, "_res0"}, {24'b0, bus.result}, 32'd0);
    endtask

    initial begin
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        bus.signed_mode = 1'b0; bus.out_ready = 1'b1;
        #12 rst = 1'b0;
        #1;
        chk("reset_inrdy", {31'b0, bus.in_ready}, 32'd1);
        chk("reset_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_result", {24'b0, bus.result}, 32'd0);

        run_op("uns_top",   8'h2F, 8'h81, 1'b0, 8'b0000_0001, 1);
        run_op("sgn_top",   8'h2F, 8'h81, 1'b1, 8'b0000_0100, 1);
        run_op("uns_sign",  8'h80, 8'h00, 1'b0, 8'b0000_0100, 1);
        run_op("sgn_sign",  8'h80, 8'h00, 1'b1, 8'b0000_0001, 1);
        run_op("equal",     8'h00, 8'h00, 1'b0, 8'b0000_0010, 4);
        run_op("last_chk",  8'h2C, 8'h2D, 1'b0, 8'b0000_0001, 4);
        run_op("mid_gt",    8'hA7, 8'hA3, 1'b0, 8'b0000_0100, 3);

        // Backpressure; a competing in_valid while busy must be ignored.
        bus.out_ready = 1'b0;
        start_op(8'h2C, 8'h2D, 1'b0);
        bus.a = 8'hFF; bus.b = 8'h00; bus.in_valid = 1'b1;
        wait_out(lat);
        check_res("bp", 8'b0000_0001, 4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_hold_result", {24'b0, bus.result}, 32'd1);
            chk("bp_hold_flags", {29'b0, bus.gt, bus.eq, bus.lt}, 32'd1);
            chk("bp_hold_inrdy", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handoff_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("bp_handoff_inrdy", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_no_second", {31'b0, bus.out_valid}, 32'd0);

        // Clear during CMP.
        start_op(8'h00, 8'h00, 1'b0);
        @(negedge clk); bus.clear = 1'b1;
        @(posedge clk); #1; bus.clear = 1'b0;
        chk("clr_inrdy", {31'b0, bus.in_ready}, 32'd1);
        chk("clr_valid", {31'b0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("clr_quiet", {31'b0, bus.out_valid}, 32'd0);
        end
        run_op("after_clr", 8'h2F, 8'h81, 1'b0, 8'b0000_0001, 1);

        // Async reset mid-CMP, asserted between edges.
        start_op(8'h00, 8'h00, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_inrdy", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_result", {24'b0, bus.result}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_quiet", {31'b0, bus.out_valid}, 32'd0);
        end
        run_op("after_rst", 8'h2F, 8'h81, 1'b0, 8'b0000_0001, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
